sram_pingpong: RTL

Parametrised double-buffered (ping-pong) on-chip buffer for the NPU datapath. It generalises the single-bank 8-bit x 1024 synchronous SRAM to two banks of configurable width and depth. A producer fills one bank while a consumer drains the other. Bank ownership passes by a done/ready handshake, so a loader and a compute engine can overlap without address arbitration.

---
 rtl/npu_sram_pkg.sv | 17 +
 rtl/sram_bank.sv | 40 ++++
 rtl/sram_pingpong.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/npu_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_sram_pkg
// Description : Shared defaults and types for the ping-pong NPU buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_sram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;
    localparam int NUM_BANKS  = 2;

    // Selects one of the two banks
    typedef logic bank_sel_t;

endpackage : npu_sram_pkg
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank
// Description : Simple dual-port bank, one write port and one registered
//               read port. The array carries no reset so it maps onto
//               block RAM. o_rdata only changes on an enabled read.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank
    import npu_sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Write port and read register; the read register holds when i_re is low
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sram_bank
`default_nettype wire

// File: rtl/sram_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : sram_pingpong
// Description : Double-buffered buffer. The producer fills the write bank
//               while the consumer drains the read bank; ownership moves by
//               wr_done / rd_done pulses. Rejected strobes raise err for one
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_pingpong
    import npu_sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              rpll_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_din,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dout,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [1:0]        full_cnt,
    output logic              err
);

    // Ownership state
    bank_sel_t              r_wsel;
    bank_sel_t              r_rsel;
    logic [NUM_BANKS-1:0]   r_full;
    bank_sel_t              w_wsel_nxt;
    bank_sel_t              w_rsel_nxt;
    logic [NUM_BANKS-1:0]   w_full_nxt;

    // Read-side registers
    logic                   r_rd_valid;
    bank_sel_t              r_rd_bank;
    logic                   r_rd_zero;
    logic                   r_err;

    logic                   w_wr_ready;
    logic                   w_rd_ready;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_commit;
    logic                   w_release;
    logic                   w_reject;
    logic [DATA_W-1:0]      w_bank_q [NUM_BANKS];

    assign w_wr_ready = !r_full[r_wsel];
    assign w_rd_ready = r_full[r_rsel];
    assign w_wr_acc   = wr_en   & w_wr_ready;
    assign w_commit   = wr_done & w_wr_ready;
    assign w_rd_acc   = rd_en   & w_rd_ready;
    assign w_release  = rd_done & w_rd_ready;
    assign w_reject   = ((wr_en | wr_done) & !w_wr_ready)
                      | ((rd_en | rd_done) & !w_rd_ready);

    // Next ownership: commit and release always touch different banks,
    // because a bank cannot be both free and full at once
    always_comb begin
        w_full_nxt = r_full;
        w_wsel_nxt = r_wsel;
        w_rsel_nxt = r_rsel;
        if (w_commit) begin
            w_full_nxt[r_wsel] = 1'b1;
            w_wsel_nxt         = ~r_wsel;
        end
        if (w_release) begin
            w_full_nxt[r_rsel] = 1'b0;
            w_rsel_nxt         = ~r_rsel;
        end
    end

    // Ownership state register
    always_ff @(posedge rpll_clk) begin
        if (rst) begin
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
            r_full <= '0;
        end else begin
            r_wsel <= w_wsel_nxt;
            r_rsel <= w_rsel_nxt;
            r_full <= w_full_nxt;
        end
    end

    // Read tracking: the bank holds the data word, here we remember which
    // bank answered last and whether any read has happened since reset
    always_ff @(posedge rpll_clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_err      <= w_reject;
            if (w_rd_acc) begin
                r_rd_bank <= r_rsel;
                r_rd_zero <= 1'b0;
            end
        end
    end

    // Two physical banks; only the currently owned bank sees the strobes
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic w_we;
        logic w_re;
        assign w_we = w_wr_acc & (r_wsel == bank_sel_t'(gi));
        assign w_re = w_rd_acc & (r_rsel == bank_sel_t'(gi));
        sram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (rpll_clk),
            .i_we    (w_we),
            .i_waddr (wr_addr),
            .i_wdata (wr_din),
            .i_re    (w_re),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_q[gi])
        );
    end

    // The selected bank register plus the post-reset zero flag forms rd_dout
    assign rd_dout  = r_rd_zero ? '0 : w_bank_q[r_rd_bank];
    assign rd_valid = r_rd_valid;
    assign err      = r_err;
    assign wr_ready = w_wr_ready;
    assign rd_ready = w_rd_ready;
    assign full_cnt = 2'(r_full[0]) + 2'(r_full[1]);

endmodule : sram_pingpong
`default_nettype wire
